// File: rtl/vec_decode_sequencer_pkg.sv
// rtl/vec_decode_sequencer_pkg.sv - vector ISA opcodes, FU selects and datapath control word
package vec_isa_pkg;

  typedef enum logic [4:0] {
    OP_VLOAD  = 5'b00000,
    OP_VSTORE = 5'b00001,
    OP_VADD   = 5'b00010,
    OP_VSUB   = 5'b00011,
    OP_VMUL   = 5'b00100,
    OP_VSMUL  = 5'b00101,
    OP_VSADD  = 5'b00110,
    OP_VFADD  = 5'b00111,
    OP_VFSUB  = 5'b01000,
    OP_VAND   = 5'b01001,
    OP_VOR    = 5'b01010,
    OP_VXOR   = 5'b01011,
    OP_VSEQ   = 5'b01100,
    OP_VSNE   = 5'b01101,
    OP_VSGT   = 5'b01110,
    OP_VSLT   = 5'b01111
  } vec_opcode_e;

  localparam logic [2:0] FU_INT  = 3'd0;
  localparam logic [2:0] FU_FP   = 3'd1;
  localparam logic [2:0] FU_MUL  = 3'd2;
  localparam logic [2:0] FU_BIT  = 3'd4;
  localparam logic [2:0] FU_PRED = 3'd5;

  typedef struct packed {
    logic       mux_bit;
    logic       vreg_we;
    logic       preg_we;
    logic       sreg_we;
    logic       vreg_load_mux;
    logic       sreg_load_mux;
    logic       add_sub;
    logic       load_store;
    logic [2:0] fu_sel;
    logic [1:0] bitwise_sel;
    logic [1:0] pred_sel;
    logic       clock_enable;
    logic       clock_bypass;
  } vec_ctrl_t;

  // Quiescent word: all FUs idle with the clock gate bypassed.
  localparam vec_ctrl_t VEC_CTRL_IDLE = '{
    mux_bit:       1'b0,
    vreg_we:       1'b0,
    preg_we:       1'b0,
    sreg_we:       1'b0,
    vreg_load_mux: 1'b0,
    sreg_load_mux: 1'b0,
    add_sub:       1'b0,
    load_store:    1'b0,
    fu_sel:        3'd0,
    bitwise_sel:   2'd0,
    pred_sel:      2'd0,
    clock_enable:  1'b0,
    clock_bypass:  1'b1
  };

endpackage

// File: rtl/vec_decode_sequencer_if.sv
// rtl/vec_decode_sequencer_if.sv - instruction in / micro-op out bundle of the decode sequencer
interface vec_decode_sequencer_if #(
  parameter int LANES    = 4,
  parameter int VLEN_MAX = 32
);
  localparam int VL_W  = $clog2(VLEN_MAX + 1);
  localparam int GRP_W = ($clog2(VLEN_MAX / LANES) > 1) ? $clog2(VLEN_MAX / LANES) : 1;

  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [VL_W-1:0]  vl;

  logic             uop_valid;
  logic             uop_ready;
  logic [4:0]       uop_vd;
  logic [4:0]       uop_vs1;
  logic [4:0]       uop_vs2;
  logic             uop_mux_bit;
  logic             uop_vreg_we;
  logic             uop_preg_we;
  logic             uop_sreg_we;
  logic             uop_vreg_load_mux;
  logic             uop_sreg_load_mux;
  logic             uop_add_sub;
  logic             uop_load_store;
  logic [2:0]       uop_fu_sel;
  logic [1:0]       uop_bitwise_sel;
  logic [1:0]       uop_pred_sel;
  logic             uop_clock_enable;
  logic             uop_clock_bypass;
  logic [GRP_W-1:0] uop_group;
  logic [LANES-1:0] uop_lane_mask;
  logic             uop_last;

  logic             illegal_instr;
  logic             busy;

  modport master (
    input  instr, instr_valid, vl, uop_ready,
    output instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2,
           uop_mux_bit, uop_vreg_we, uop_preg_we, uop_sreg_we,
           uop_vreg_load_mux, uop_sreg_load_mux, uop_add_sub, uop_load_store,
           uop_fu_sel, uop_bitwise_sel, uop_pred_sel,
           uop_clock_enable, uop_clock_bypass,
           uop_group, uop_lane_mask, uop_last, illegal_instr, busy
  );

  modport slave (
    output instr, instr_valid, vl, uop_ready,
    input  instr_ready, uop_valid, uop_vd, uop_vs1, uop_vs2,
           uop_mux_bit, uop_vreg_we, uop_preg_we, uop_sreg_we,
           uop_vreg_load_mux, uop_sreg_load_mux, uop_add_sub, uop_load_store,
           uop_fu_sel, uop_bitwise_sel, uop_pred_sel,
           uop_clock_enable, uop_clock_bypass,
           uop_group, uop_lane_mask, uop_last, illegal_instr, busy
  );

endinterface

// File: rtl/vec_decode_sequencer_op_decode.sv
// rtl/vec_decode_sequencer_op_decode.sv - combinational opcode to control-word decoder
module vec_op_decode
  import vec_isa_pkg::*;
(
  input  logic [4:0] opcode,
  output vec_ctrl_t  ctrl,
  output logic       legal
);

  always_comb begin
    ctrl  = VEC_CTRL_IDLE;
    legal = ~opcode[4];

    // Everything legal other than load/store runs through a clocked FU.
    if (legal && (opcode[4:1] != 4'b0000)) begin
      ctrl.clock_enable = 1'b1;
      ctrl.clock_bypass = 1'b0;
      ctrl.vreg_we      = 1'b1;
    end

    case (opcode)
      OP_VLOAD: begin
        ctrl.load_store = 1'b1;
        ctrl.vreg_we    = 1'b1;
      end
      OP_VSTORE: begin
        ctrl.load_store = 1'b1;
      end
      OP_VADD, OP_VSUB, OP_VSADD: begin
        ctrl.fu_sel  = FU_INT;
        ctrl.add_sub = (opcode == OP_VSUB);
        ctrl.mux_bit = (opcode == OP_VSADD);
      end
      OP_VMUL, OP_VSMUL: begin
        ctrl.fu_sel  = FU_MUL;
        ctrl.mux_bit = (opcode == OP_VSMUL);
      end
      OP_VFADD, OP_VFSUB: begin
        ctrl.fu_sel  = FU_FP;
        ctrl.add_sub = (opcode == OP_VFSUB);
      end
      OP_VAND, OP_VOR, OP_VXOR: begin
        ctrl.fu_sel      = FU_BIT;
        ctrl.bitwise_sel = opcode[1:0];
      end
      OP_VSEQ, OP_VSNE, OP_VSGT, OP_VSLT: begin
        ctrl.fu_sel   = FU_PRED;
        ctrl.preg_we  = 1'b1;
        ctrl.vreg_we  = 1'b0;
        ctrl.pred_sel = opcode[1:0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/vec_decode_sequencer.sv
// rtl/vec_decode_sequencer.sv - vector instruction decode and per-lane-group micro-op issue
module vec_decode_sequencer
  import vec_isa_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int VLEN_MAX = 32
) (
  input logic                    clk,
  input logic                    reset,
  vec_decode_sequencer_if.master bus
);

  localparam int VL_W  = $clog2(VLEN_MAX + 1);
  localparam int GRP_W = ($clog2(VLEN_MAX / LANES) > 1) ? $clog2(VLEN_MAX / LANES) : 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e           state_q, state_d;
  vec_ctrl_t        ctrl_q, ctrl_d;
  logic [4:0]       vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VL_W-1:0]  vlc_q, vlc_d;
  logic [GRP_W-1:0] group_q, group_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;

  vec_ctrl_t        dec_ctrl;
  logic             dec_legal;
  logic [VL_W-1:0]  vl_clamp;
  logic             accept;
  logic             uop_fire;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^{bus.instr[26], bus.instr[10:0]};

  vec_op_decode u_decode (
    .opcode (bus.instr[31:27]),
    .ctrl   (dec_ctrl),
    .legal  (dec_legal)
  );

  function automatic logic [LANES-1:0] group_mask(input int grp, input int vlc);
    group_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      group_mask[i] = (grp * LANES + i) < vlc;
    end
  endfunction

  function automatic logic group_last(input int grp, input int vlc);
    return ((grp + 1) * LANES) >= vlc;
  endfunction

  assign vl_clamp = (int'(bus.vl) > VLEN_MAX) ? VL_W'(VLEN_MAX) : bus.vl;

  // The single comb path: a finishing last micro-op frees the stage this cycle.
  assign bus.instr_ready = (state_q == S_IDLE) ||
                           ((state_q == S_ISSUE) && bus.uop_ready && last_q);
  assign accept   = bus.instr_valid && bus.instr_ready;
  assign uop_fire = valid_q && bus.uop_ready;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    vd_d      = vd_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vlc_d     = vlc_q;
    group_d   = group_q;
    mask_d    = mask_q;
    last_d    = last_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;

    if (uop_fire) begin
      if (last_q) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end else begin
        group_d = group_q + GRP_W'(1);
        mask_d  = group_mask(int'(group_q) + 1, int'(vlc_q));
        last_d  = group_last(int'(group_q) + 1, int'(vlc_q));
      end
    end

    // A new instruction overrides the return to IDLE for zero-bubble issue.
    if (accept) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
      end else if (vl_clamp != '0) begin
        state_d = S_ISSUE;
        valid_d = 1'b1;
        ctrl_d  = dec_ctrl;
        vd_d    = bus.instr[25:21];
        vs1_d   = bus.instr[20:16];
        vs2_d   = bus.instr[15:11];
        vlc_d   = vl_clamp;
        group_d = '0;
        mask_d  = group_mask(0, int'(vl_clamp));
        last_d  = group_last(0, int'(vl_clamp));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= VEC_CTRL_IDLE;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vlc_q     <= '0;
      group_q   <= '0;
      mask_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vlc_q     <= vlc_d;
      group_q   <= group_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.uop_valid         = valid_q;
  assign bus.uop_vd            = vd_q;
  assign bus.uop_vs1           = vs1_q;
  assign bus.uop_vs2           = vs2_q;
  assign bus.uop_mux_bit       = ctrl_q.mux_bit;
  assign bus.uop_vreg_we       = ctrl_q.vreg_we;
  assign bus.uop_preg_we       = ctrl_q.preg_we;
  assign bus.uop_sreg_we       = ctrl_q.sreg_we;
  assign bus.uop_vreg_load_mux = ctrl_q.vreg_load_mux;
  assign bus.uop_sreg_load_mux = ctrl_q.sreg_load_mux;
  assign bus.uop_add_sub       = ctrl_q.add_sub;
  assign bus.uop_load_store    = ctrl_q.load_store;
  assign bus.uop_fu_sel        = ctrl_q.fu_sel;
  assign bus.uop_bitwise_sel   = ctrl_q.bitwise_sel;
  assign bus.uop_pred_sel      = ctrl_q.pred_sel;
  assign bus.uop_clock_enable  = ctrl_q.clock_enable;
  assign bus.uop_clock_bypass  = ctrl_q.clock_bypass;
  assign bus.uop_group         = group_q;
  assign bus.uop_lane_mask     = mask_q;
  assign bus.uop_last          = last_q;
  assign bus.illegal_instr     = illegal_q;
  assign bus.busy              = (state_q != S_IDLE);

endmodule
